feed_forward_node: RTL and testbench

Single neuron (processing element) of the DQN feed-forward engine: accumulates a stream of IEEE-754 single-precision weight×input products plus bias, applies an activation, and emits one result per neuron. The layer controller instantiates it three times: input→hidden 1 (2 inputs, ReLU), hidden 1→hidden 2 (24 inputs, ReLU), and hidden 2→output (24 inputs, linear Q-values). It replaces the three per-layer node variants with one parameterized block.

---
 rtl/feed_forward_node_pkg.sv | 142 ++++++++++++++
 rtl/feed_forward_node_if.sv | 13 +
 rtl/feed_forward_node_fp_mac_stage.sv | 57 +++++
 rtl/feed_forward_node.sv | 59 +++++
 tb/tb_feed_forward_node.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/feed_forward_node_pkg.sv
// Shared binary32 helpers for the DQN feed-forward datapath.
// fp_mul / fp_add are single-cycle combinational operators with
// round-to-nearest-even, flush-to-zero on subnormals and a canonical quiet NaN.
package feed_forward_node_pkg;

  localparam int FP_WIDTH  = 32;
  localparam int FP_EXP_W  = 8;
  localparam int FP_MAN_W  = 23;

  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

  // Product of two binary32 values.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic sa, sb, sr;
    logic [7:0] ea, eb;
    logic [22:0] fa, fb;
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [47:0] prod;
    logic [24:0] mant;
    logic guard, sticky;
    logic signed [9:0] e;
    logic [31:0] r;
    sa = a[31]; ea = a[30:23]; fa = a[22:0];
    sb = b[31]; eb = b[30:23]; fb = b[22:0];
    // exponent 0 covers both true zero and subnormals (treated as zero)
    a_zero = (ea == 8'h00);
    b_zero = (eb == 8'h00);
    a_inf  = (ea == 8'hFF) && (fa == 23'd0);
    b_inf  = (eb == 8'hFF) && (fb == 23'd0);
    a_nan  = (ea == 8'hFF) && (fa != 23'd0);
    b_nan  = (eb == 8'hFF) && (fb != 23'd0);
    sr = sa ^ sb;
    prod = 48'({1'b1, fa}) * 48'({1'b1, fb});
    e = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
    if (prod[47]) begin
      mant   = {1'b0, prod[47:24]};
      guard  = prod[23];
      sticky = |prod[22:0];
      e      = e + 10'sd1;
    end else begin
      mant   = {1'b0, prod[46:23]};
      guard  = prod[22];
      sticky = |prod[21:0];
    end
    if (guard && (sticky || mant[0])) mant = mant + 25'd1;
    if (mant[24]) begin
      mant = mant >> 1;
      e    = e + 10'sd1;
    end
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) r = FP_QNAN;
    else if (a_inf || b_inf)                                      r = {sr, 8'hFF, 23'd0};
    else if (a_zero || b_zero)                                    r = {sr, 31'd0};
    else if (e >= 10'sd255)                                       r = {sr, 8'hFF, 23'd0};
    else if (e <= 10'sd0)                                         r = FP_ZERO;
    else                                                          r = {sr, e[7:0], mant[22:0]};
    return r;
  endfunction

  // Sum of two binary32 values.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic sa, sb, sl, ss;
    logic [7:0] ea, eb, el, es, dexp;
    logic [22:0] fa, fb, fl, fs;
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, zero_res, found;
    logic [26:0] ml, ms, ms_sh;
    logic [27:0] s;
    logic [24:0] mant;
    logic guard, sticky;
    logic [4:0] lz;
    logic signed [9:0] e;
    logic [31:0] r;
    sa = a[31]; ea = a[30:23]; fa = a[22:0];
    sb = b[31]; eb = b[30:23]; fb = b[22:0];
    a_zero = (ea == 8'h00);
    b_zero = (eb == 8'h00);
    a_inf  = (ea == 8'hFF) && (fa == 23'd0);
    b_inf  = (eb == 8'hFF) && (fb == 23'd0);
    a_nan  = (ea == 8'hFF) && (fa != 23'd0);
    b_nan  = (eb == 8'hFF) && (fb != 23'd0);
    // order operands by magnitude so the subtraction below never goes negative
    if ({ea, fa} >= {eb, fb}) begin
      sl = sa; el = ea; fl = fa; ss = sb; es = eb; fs = fb;
    end else begin
      sl = sb; el = eb; fl = fb; ss = sa; es = ea; fs = fa;
    end
    dexp = el - es;
    // three extra LSBs hold guard, round and sticky
    ml = {1'b1, fl, 3'b000};
    ms = {1'b1, fs, 3'b000};
    if (dexp > 8'd26) begin
      ms_sh = 27'd1;
    end else begin
      ms_sh = ms >> dexp;
      if (|(ms & ((27'd1 << dexp) - 27'd1))) ms_sh[0] = 1'b1;
    end
    e = $signed({2'b00, el});
    zero_res = 1'b0;
    found = 1'b0;
    lz = 5'd0;
    if (sl == ss) begin
      s = {1'b0, ml} + {1'b0, ms_sh};
      if (s[27]) begin
        s = {1'b0, s[27:2], s[1] | s[0]};
        e = e + 10'sd1;
      end
    end else begin
      s = {1'b0, ml} - {1'b0, ms_sh};
      zero_res = (s == 28'd0);
      for (int i = 26; i >= 0; i--) begin
        if (!found && s[i]) begin
          lz = 5'(26 - i);
          found = 1'b1;
        end
      end
      s = s << lz;
      e = e - $signed({5'b00000, lz});
    end
    mant   = {1'b0, s[26:3]};
    guard  = s[2];
    sticky = |s[1:0];
    if (guard && (sticky || mant[0])) mant = mant + 25'd1;
    if (mant[24]) begin
      mant = mant >> 1;
      e    = e + 10'sd1;
    end
    if (a_nan || b_nan)               r = FP_QNAN;
    else if (a_inf && b_inf)          r = (sa != sb) ? FP_QNAN : a;
    else if (a_inf)                   r = a;
    else if (b_inf)                   r = b;
    else if (a_zero && b_zero)        r = {sa & sb, 31'd0};
    else if (a_zero)                  r = b;
    else if (b_zero)                  r = a;
    else if (zero_res)                r = FP_ZERO;
    else if (e >= 10'sd255)           r = {sl, 8'hFF, 23'd0};
    else if (e <= 10'sd0)             r = FP_ZERO;
    else                              r = {sl, e[7:0], mant[22:0]};
    return r;
  endfunction

endpackage

// File: rtl/feed_forward_node_if.sv
// Pair-stream / result bus of one feed-forward neuron.
interface feed_forward_node_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  i_valid;
  logic [DATA_WIDTH-1:0] i_weight;
  logic [DATA_WIDTH-1:0] i_data;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_valid;

  modport master (output i_valid, i_weight, i_data, input o_data, o_valid);
  modport slave  (input i_valid, i_weight, i_data, output o_data, o_valid);
endinterface

// File: rtl/feed_forward_node_fp_mac_stage.sv
// Two-stage multiply-accumulate: registered product, then running sum.
// The completed sum is captured only on the neuron's last pair.
module fp_mac_stage
  import feed_forward_node_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] in_weight,
  input  logic [31:0] in_data,
  input  logic        in_first,
  input  logic        in_last,
  output logic        sum_valid,
  output logic [31:0] sum_data
);
  logic        p_valid_reg;
  logic        p_first_reg;
  logic        p_last_reg;
  logic [31:0] p_reg;
  logic [31:0] acc_reg;
  logic [31:0] sum_reg;
  logic        sum_valid_reg;
  logic [31:0] acc_next;

  // First pair of a neuron restarts from +0 so no earlier sum leaks in
  always_comb begin
    acc_next = fp_add(p_first_reg ? FP_ZERO : acc_reg, p_reg);
  end

  // Product register, accumulator and result capture
  always_ff @(posedge clk) begin
    if (rst_n) begin
      p_valid_reg   <= 1'b0;
      p_first_reg   <= 1'b0;
      p_last_reg    <= 1'b0;
      p_reg         <= FP_ZERO;
      acc_reg       <= FP_ZERO;
      sum_reg       <= FP_ZERO;
      sum_valid_reg <= 1'b0;
    end else begin
      p_valid_reg <= in_valid;
      if (in_valid) begin
        p_reg       <= fp_mul(in_weight, in_data);
        p_first_reg <= in_first;
        p_last_reg  <= in_last;
      end
      sum_valid_reg <= p_valid_reg && p_last_reg;
      if (p_valid_reg) begin
        acc_reg <= acc_next;
        if (p_last_reg) sum_reg <= acc_next;
      end
    end
  end

  assign sum_valid = sum_valid_reg;
  assign sum_data  = sum_reg;
endmodule

// File: rtl/feed_forward_node.sv
// One DQN neuron: sums N weight*input products plus a bias pair and
// applies ReLU or identity. Only DATA_WIDTH = 32 (binary32) is meaningful.
// rst_n is a synchronous, active-high reset despite its name.
module feed_forward_node
  import feed_forward_node_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int NUMBER_OF_INPUTS = 2,
  parameter int RELU             = 1
) (
  input logic               clk,
  input logic               rst_n,
  feed_forward_node_if.slave bus
);
  localparam int CNT_W = (NUMBER_OF_INPUTS < 1) ? 1 : $clog2(NUMBER_OF_INPUTS + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUMBER_OF_INPUTS);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             sum_valid;
  logic [31:0]      sum_data;
  logic [31:0]      act_data;

  // Pair index 0..N; the bias pair (index N) closes the neuron
  always_comb begin
    cnt_next = cnt_reg;
    if (bus.i_valid) cnt_next = (cnt_reg == LAST_IDX) ? '0 : cnt_reg + CNT_W'(1);
  end

  // Pair counter register
  always_ff @(posedge clk) begin
    if (rst_n) cnt_reg <= '0;
    else       cnt_reg <= cnt_next;
  end

  fp_mac_stage u_mac (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.i_valid),
    .in_weight (bus.i_weight[31:0]),
    .in_data   (bus.i_data[31:0]),
    .in_first  (cnt_reg == '0),
    .in_last   (cnt_reg == LAST_IDX),
    .sum_valid (sum_valid),
    .sum_data  (sum_data)
  );

  // Activation on the registered sum; any set sign bit (-0, negative NaN) clamps to 0
  generate
    if (RELU != 0) begin : g_relu
      assign act_data = sum_data[31] ? FP_ZERO : sum_data;
    end else begin : g_linear
      assign act_data = sum_data;
    end
  endgenerate

  assign bus.o_data  = DATA_WIDTH'(act_data);
  assign bus.o_valid = sum_valid;
endmodule

// File: tb/tb_feed_forward_node.sv
// Directed bench: three neurons (N=2 ReLU, N=2 linear, N=24 ReLU).
module tb_feed_forward_node;
  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   c_pulses = 0;
  logic [31:0] c_last = 32'h0;
  int          qa_cyc[$];
  logic [31:0] qa_dat[$];
  logic [31:0] qb_dat[$];

  feed_forward_node_if #(.DATA_WIDTH(32)) bus_a ();
  feed_forward_node_if #(.DATA_WIDTH(32)) bus_b ();
  feed_forward_node_if #(.DATA_WIDTH(32)) bus_c ();

  // the linear N=2 neuron sees exactly the same pair stream as the ReLU one
  assign bus_b.i_valid  = bus_a.i_valid;
  assign bus_b.i_weight = bus_a.i_weight;
  assign bus_b.i_data   = bus_a.i_data;

  feed_forward_node #(.DATA_WIDTH(32), .NUMBER_OF_INPUTS(2),  .RELU(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  feed_forward_node #(.DATA_WIDTH(32), .NUMBER_OF_INPUTS(2),  .RELU(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
  feed_forward_node #(.DATA_WIDTH(32), .NUMBER_OF_INPUTS(24), .RELU(1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus_a.o_valid) begin
      qa_cyc.push_back(cyc);
      qa_dat.push_back(bus_a.o_data);
    end
    if (bus_b.o_valid) qb_dat.push_back(bus_b.o_data);
    if (bus_c.o_valid) begin
      c_pulses <= c_pulses + 1;
      c_last   <= bus_c.o_data;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic pair_a(input logic [31:0] w, input logic [31:0] d);
    bus_a.i_valid = 1'b1; bus_a.i_weight = w; bus_a.i_data = d;
    @(negedge clk);
    bus_a.i_valid = 1'b0;
  endtask

  task automatic pair_c(input logic [31:0] w, input logic [31:0] d);
    bus_c.i_valid = 1'b1; bus_c.i_weight = w; bus_c.i_data = d;
    @(negedge clk);
    bus_c.i_valid = 1'b0;
  endtask

  typedef struct {
    logic [31:0] w0, w1, w2;
    logic [31:0] d0, d1, d2;
    logic [31:0] exp_relu, exp_lin;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    // weights | data | expected ReLU | expected linear
    vecs[0] = '{32'h3F800000, 32'h40000000, 32'h3F000000, 32'h40400000, 32'h40800000, 32'h3F800000, 32'h41380000, 32'h41380000};
    vecs[1] = '{32'hBF800000, 32'hBF800000, 32'h3F000000, 32'h40400000, 32'h40800000, 32'h3F800000, 32'h00000000, 32'hC0D00000};
    vecs[2] = '{32'h7F800000, 32'h3F800000, 32'h3F800000, 32'h00000000, 32'h3F800000, 32'h3F800000, 32'h7FC00000, 32'h7FC00000};
    vecs[3] = '{32'h3F800000, 32'h40000000, 32'h3F000000, 32'h00000001, 32'h3F800000, 32'h3F800000, 32'h40200000, 32'h40200000};
    vecs[4] = '{32'h3F800001, 32'h00000000, 32'h00000000, 32'h3F800001, 32'h3F800000, 32'h3F800000, 32'h3F800002, 32'h3F800002};
    vecs[5] = '{32'h7F000000, 32'h00000000, 32'h00000000, 32'h40000000, 32'h3F800000, 32'h3F800000, 32'h7F800000, 32'h7F800000};
    vecs[6] = '{32'h3F800000, 32'h33800000, 32'h00000000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
    vecs[7] = '{32'h3F800001, 32'h33800000, 32'h00000000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800002, 32'h3F800002};

    bus_a.i_valid = 1'b0; bus_a.i_weight = 32'h0; bus_a.i_data = 32'h0;
    bus_c.i_valid = 1'b0; bus_c.i_weight = 32'h0; bus_c.i_data = 32'h0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    check("reset_a_valid", {31'b0, bus_a.o_valid}, 32'd0);
    check("reset_a_data", bus_a.o_data, 32'h0);
    check("reset_b_valid", {31'b0, bus_b.o_valid}, 32'd0);
    check("reset_b_data", bus_b.o_data, 32'h0);
    check("reset_c_valid", {31'b0, bus_c.o_valid}, 32'd0);
    check("reset_c_data", bus_c.o_data, 32'h0);
    @(negedge clk);

    // table: three pairs per neuron, pulse expected in the second cycle after the bias pair
    for (int v = 0; v < 8; v++) begin
      pair_a(vecs[v].w0, vecs[v].d0);
      pair_a(vecs[v].w1, vecs[v].d1);
      pair_a(vecs[v].w2, vecs[v].d2);
      check($sformatf("v%0d_early_valid", v), {31'b0, bus_a.o_valid}, 32'd0);
      @(negedge clk);
      check($sformatf("v%0d_pulse_a", v), {31'b0, bus_a.o_valid}, 32'd1);
      check($sformatf("v%0d_pulse_b", v), {31'b0, bus_b.o_valid}, 32'd1);
      check($sformatf("v%0d_relu", v), bus_a.o_data, vecs[v].exp_relu);
      check($sformatf("v%0d_lin", v), bus_b.o_data, vecs[v].exp_lin);
      @(negedge clk);
      check($sformatf("v%0d_pulse_end", v), {31'b0, bus_a.o_valid}, 32'd0);
      check($sformatf("v%0d_hold", v), bus_b.o_data, vecs[v].exp_lin);
      $display("vector %0d: relu=%08h lin=%08h", v, bus_a.o_data, bus_b.o_data);
    end

    // back-to-back neurons: pulses 3 cycles apart, second sum independent
    qa_cyc.delete(); qa_dat.delete(); qb_dat.delete();
    for (int v = 0; v < 2; v++) begin
      bus_a.i_valid = 1'b1;
      bus_a.i_weight = vecs[v].w0; bus_a.i_data = vecs[v].d0; @(negedge clk);
      bus_a.i_weight = vecs[v].w1; bus_a.i_data = vecs[v].d1; @(negedge clk);
      bus_a.i_weight = vecs[v].w2; bus_a.i_data = vecs[v].d2; @(negedge clk);
    end
    bus_a.i_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("b2b_pulse_count", qa_dat.size(), 32'd2);
    if (qa_dat.size() >= 2 && qb_dat.size() >= 2) begin
      check("b2b_spacing", qa_cyc[1] - qa_cyc[0], 32'd3);
      check("b2b_first_relu", qa_dat[0], 32'h41380000);
      check("b2b_second_relu", qa_dat[1], 32'h00000000);
      check("b2b_second_lin", qb_dat[1], 32'hC0D00000);
    end
    $display("back-to-back: %0d pulses", qa_dat.size());

    // reset mid-neuron: partial sum and in-flight product are dropped
    qa_cyc.delete(); qa_dat.delete(); qb_dat.delete();
    pair_a(vecs[1].w0, vecs[1].d0);
    pair_a(vecs[1].w1, vecs[1].d1);
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    check("midrst_valid", {31'b0, bus_a.o_valid}, 32'd0);
    check("midrst_data_b", bus_b.o_data, 32'h0);
    @(negedge clk);
    pair_a(vecs[0].w0, vecs[0].d0);
    pair_a(vecs[0].w1, vecs[0].d1);
    pair_a(vecs[0].w2, vecs[0].d2);
    repeat (4) @(negedge clk);
    check("midrst_pulse_count", qb_dat.size(), 32'd1);
    if (qb_dat.size() >= 1) check("midrst_result", qb_dat[0], 32'h41380000);
    $display("mid-neuron reset: %0d pulses", qb_dat.size());

    // N=24: 25 pairs of 1.0*1.0 with random idle gaps
    base = c_pulses;
    for (int k = 0; k < 25; k++) begin
      if (k == 24) check("n24_no_early_pulse", c_pulses - base, 32'd0);
      pair_c(32'h3F800000, 32'h3F800000);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check("n24_pulse_count", c_pulses - base, 32'd1);
    check("n24_result", c_last, 32'h41C80000);
    $display("n24: %0d pulses result=%08h", c_pulses - base, c_last);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
